// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between the IF and MEM stages,
//            data port first with fetch starvation protection.
//            Define ARB_PERF_CNT_EN to add per-port stall-cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       if_stall_cnt,
    output logic [15:0]       dm_stall_cnt
`endif
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    localparam logic [3:0] c_lat_m1     = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] c_starve_lim = 4'(STARVE_LIMIT);
    localparam logic       c_single_lat = (MEM_LATENCY == 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_win_dm;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_cnt;
    logic [3:0]        r_starve;

    logic w_arb;
    logic w_grant_dm;
    logic w_grant_if;

    // Fetch overrides the data port only once it has lost STARVE_LIMIT times in a row.
    assign w_arb      = (r_state == c_st_idle) || (r_state == c_st_resp);
    assign w_grant_dm = w_arb && dm_req && !(if_req && (r_starve == c_starve_lim));
    assign w_grant_if = w_arb && !w_grant_dm && if_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_win_dm <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
            r_starve <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_dm || w_grant_if) begin
                r_win_dm <= w_grant_dm;
                r_we     <= w_grant_dm & dm_we;
                r_addr   <= w_grant_dm ? dm_addr : if_addr;
                r_wdata  <= w_grant_dm ? dm_wdata : '0;
            end
            if (w_arb) begin
                if (if_req && w_grant_dm) begin
                    if (r_starve != c_starve_lim) begin
                        r_starve <= r_starve + 4'd1;
                    end
                end else begin
                    r_starve <= '0;
                end
            end
            if ((r_state == c_st_issue) && !r_we) begin
                r_cnt <= c_lat_m1;
            end else if ((r_state == c_st_wait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        dm_rvalid   = 1'b0;
        dm_rdata    = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        busy        = (r_state != c_st_idle);

        case (r_state)
            c_st_idle: begin
                w_state_nxt = (w_grant_dm || w_grant_if) ? c_st_issue : c_st_idle;
            end
            c_st_issue: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                dm_gnt    = r_win_dm;
                if_gnt    = !r_win_dm;
                w_state_nxt = (r_we || c_single_lat) ? c_st_resp : c_st_wait;
            end
            c_st_wait: begin
                // The count still shows 1 in the last wait cycle, so leave here.
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: begin
                if (r_win_dm) begin
                    dm_rvalid = 1'b1;
                    dm_rdata  = r_we ? '0 : mem_rdata;
                end else begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
                w_state_nxt = (w_grant_dm || w_grant_if) ? c_st_issue : c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

`ifdef ARB_PERF_CNT_EN
    logic [15:0] r_if_stall;
    logic [15:0] r_dm_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_stall <= '0;
            r_dm_stall <= '0;
        end else begin
            if (if_req && !if_gnt && (r_if_stall != 16'hFFFF)) begin
                r_if_stall <= r_if_stall + 16'd1;
            end
            if (dm_req && !dm_gnt && (r_dm_stall != 16'hFFFF)) begin
                r_dm_stall <= r_dm_stall + 16'd1;
            end
        end
    end

    assign if_stall_cnt = r_if_stall;
    assign dm_stall_cnt = r_dm_stall;
`endif

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the 5-stage pipeline.
- Arbitrates one transaction at a time.
- Data port has fixed priority, with starvation protection for fetch.
- Sequences the memory's fixed read latency and returns read data or write acks to the winning requester.
- Requesters stall their pipeline stage on req && !gnt.

Parameters:
ADDR_W, 32, address width (byte address, word-aligned)
DATA_W, 32, data width
MEM_LATENCY, 2, cycles from mem_en to valid mem_rdata; legal range 1..15
STARVE_LIMIT, 4, consecutive lost arbitrations after which IF wins next; legal range 1..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch read request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle grant pulse; request consumed
if_rvalid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  fetch data
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_gnt
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  one-cycle grant pulse
dm_rvalid  out  1  load data valid, or store ack
dm_rdata  out  DATA_W  load data; 0 on store ack
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en
busy  out  1  high when state != IDLE

Behaviour:
- Interface: one clock (clk); asynchronous, active-high reset (reset).
- Reset: state=IDLE. All outputs 0, latency counter 0, starvation counter 0. An in-flight transaction is dropped: no rvalid, no gnt. After release, requesters must re-issue (still-held req is re-arbitrated).
- States: IDLE, ISSUE, WAIT, RESP.
- Arbitration: evaluated in IDLE and RESP.
  - Winner = dm if dm_req && !(if_req && starve_cnt == STARVE_LIMIT); else if if_req, winner = if.
  - Winner, address, data and we are registered on the edge; next state = ISSUE.
  - No request: IDLE→IDLE; RESP→IDLE.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each arbitration where if_req=1 and dm wins.
  - Clears when IF wins or if_req=0.
- ISSUE (1 cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata from latched request; winner's gnt=1.
  - Load/fetch: counter loaded with MEM_LATENCY-1; next = WAIT if MEM_LATENCY>1, else RESP.
  - Store: next = RESP, no wait.
- WAIT: counter decrements each cycle; at 0 → RESP. mem_en=0.
- RESP (1 cycle):
  - Read: winner's rvalid=1; rdata = mem_rdata (combinational pass-through, sampled in this cycle).
  - Store: dm_rvalid=1, dm_rdata=0.
  - Arbitration runs in the same cycle, so back-to-back issue is possible.
- Timing (read, MEM_LATENCY=L): req seen at cycle t (IDLE) → gnt/mem_en at t+1 → rvalid at t+1+L. Read throughput: one per L+1 cycles. Store throughput: one per 2 cycles.
- Non-winning rvalid/rdata outputs are 0. gnt is never asserted without a matching req in the arbitrating cycle.
- A req dropped before gnt is legal and has no effect.
- Simultaneous if_req/dm_req with starve_cnt < STARVE_LIMIT: dm wins.
- mem_addr/mem_wdata/mem_we are 0 outside ISSUE.

Optional Feature:
ARB_PERF_CNT_EN
- Defined: adds outputs if_stall_cnt[15:0] and dm_stall_cnt[15:0].
  - Each is a saturating count of cycles with req=1 and gnt=0 for that port.
  - Cleared by reset only.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Single fetch, MEM_LATENCY=2: if_req at cycle 0, if_addr=0x10 → if_gnt and mem_en at cycle 1 with mem_addr=0x10; if_rvalid at cycle 3 with if_rdata=mem_rdata (e.g. 0x00A00093); busy 1..3.
- Collision: if_req and dm_req (load, 0x40) both at cycle 0 → dm_gnt cycle 1; dm_rvalid cycle 3; if_gnt cycle 4 (issued from RESP); if_rvalid cycle 6.
- Starvation, STARVE_LIMIT=2: dm_req and if_req held continuously → dm, dm, then if granted on the third arbitration; starve_cnt back to 0.
- Store: dm_req, dm_we=1, addr=0x80, wdata=0xDEADBEEF → cycle 1: mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF; cycle 2: dm_rvalid=1, dm_rdata=0.
- Reset mid-WAIT: assert reset asynchronously in cycle 2 of a fetch → all outputs 0 immediately; no if_rvalid; held if_req re-granted 2 cycles after reset release.
- ARB_PERF_CNT_EN: collision scenario → if_stall_cnt=4, dm_stall_cnt=1 at end.
